mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 16 +
 rtl/mult_div_unit.sv | 120 ++++++++++++
 tb/tb_mult_div_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared CPU constants for the multiply/divide unit: MDUOp encodings and datapath width.
package mult_div_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'b0000,
        MDU_MULT  = 4'b0001,
        MDU_MULTU = 4'b0010,
        MDU_DIV   = 4'b0011,
        MDU_DIVU  = 4'b0100,
        MDU_MTHI  = 4'b0101,
        MDU_MTLO  = 4'b0110
    } mdu_op_e;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. Busy mirrors a countdown that
// models the pipeline stall length; the result is written on the edge that empties it.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [3:0]      MDUOp,
    input  logic            Start,
    output logic            Busy,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  op_a, op_b;
    mdu_op_e          op_q;

    logic [2*XLEN-1:0] prod_s, prod_u;
    logic [XLEN-1:0]   a_mag, b_mag, divisor_s, divisor_u;
    logic [XLEN-1:0]   q_mag, r_mag, q_u, r_u;
    logic [XLEN-1:0]   res_hi, res_lo;
    logic              res_we;

    // Signed division goes through magnitudes so 0x80000000 / -1 wraps cleanly
    // instead of relying on tool-specific signed-overflow behaviour.
    assign prod_s    = $signed({{XLEN{op_a[XLEN-1]}}, op_a}) * $signed({{XLEN{op_b[XLEN-1]}}, op_b});
    assign prod_u    = {{XLEN{1'b0}}, op_a} * {{XLEN{1'b0}}, op_b};
    assign a_mag     = op_a[XLEN-1] ? -op_a : op_a;
    assign b_mag     = op_b[XLEN-1] ? -op_b : op_b;
    assign divisor_s = (op_b == '0) ? XLEN'(1) : b_mag;
    assign divisor_u = (op_b == '0) ? XLEN'(1) : op_b;
    assign q_mag     = a_mag / divisor_s;
    assign r_mag     = a_mag % divisor_s;
    assign q_u       = op_a / divisor_u;
    assign r_u       = op_a % divisor_u;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        res_we = 1'b0;
        res_hi = HI;
        res_lo = LO;
        case (op_q)
            MDU_MULT: begin
                res_we = 1'b1;
                {res_hi, res_lo} = prod_s;
            end
            MDU_MULTU: begin
                res_we = 1'b1;
                {res_hi, res_lo} = prod_u;
            end
            MDU_DIV: begin
                res_we = (op_b != '0);
                res_lo = (op_a[XLEN-1] ^ op_b[XLEN-1]) ? -q_mag : q_mag;
                res_hi = op_a[XLEN-1] ? -r_mag : r_mag;
            end
            MDU_DIVU: begin
                res_we = (op_b != '0);
                res_lo = q_u;
                res_hi = r_u;
            end
            default: ;
        endcase
    end

    // NOTE: all state here is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            Busy  <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            op_q  <= MDU_NONE;
            HI    <= '0;
            LO    <= '0;
        end else if (count != '0) begin
            // Busy: any Start is ignored, only the countdown advances.
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
                Busy <= 1'b0;
                if (res_we) begin
                    HI <= res_hi;
                    LO <= res_lo;
                end
            end
        end else if (Start) begin
            case (MDUOp)
                MDU_MULT, MDU_MULTU: begin
                    op_a  <= A;
                    op_b  <= B;
                    op_q  <= mdu_op_e'(MDUOp);
                    count <= MULT_LOAD;
                    Busy  <= (MULT_LOAD != '0);
                end
                MDU_DIV, MDU_DIVU: begin
                    op_a  <= A;
                    op_b  <= B;
                    op_q  <= mdu_op_e'(MDUOp);
                    count <= DIV_LOAD;
                    Busy  <= (DIV_LOAD != '0);
                end
                MDU_MTHI: HI <= A;
                MDU_MTLO: LO <= A;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI, LO;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] m_hi, m_lo;

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDUOp (MDUOp),
        .Start (Start),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: what HI/LO should hold once an operation has completed.
    task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, q, r;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
            4'd2: begin up = 64'(a) * 64'(b); m_hi = up[63:32]; m_lo = up[31:0]; end
            4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
            4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic int expected_busy(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2) return MULT_N;
        if (op == 4'd3 || op == 4'd4) return DIV_N;
        return 0;
    endfunction

    // Issue one op, then count Busy cycles (bounded); optionally scramble A/B meanwhile.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, output int cycles);
        MDUOp = op; A = a; B = b; Start = 1'b1;
        tick();
        Start = 1'b0; MDUOp = 4'd0;
        cycles = 0;
        while (Busy && cycles < 100) begin
            if (scramble) begin A = $urandom; B = $urandom; end
            tick();
            cycles++;
        end
        model_apply(op, a, b);
    endtask

    task automatic check_result(input string name, input logic [3:0] op, input int cycles);
        tests_run++;
        if (cycles !== expected_busy(op)) begin
            tests_failed++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, cycles, expected_busy(op));
        end
        tests_run++;
        if (HI !== m_hi || LO !== m_lo) begin
            tests_failed++;
            $display("FAIL %s hi_lo: got %h_%h expected %h_%h", name, HI, LO, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; Start = 1'b0; MDUOp = 4'd0; A = '1; B = '1;
        tick(); tick();
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        tests_run++;
        if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b hi=%h lo=%h expected 0/0/0", Busy, HI, LO);
        end
    endtask

    task automatic test_mult();
        int c;
        run_op(4'd1, 32'hFFFFFFFF, 32'h00000002, 1'b1, c);
        tests_run++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE || c !== MULT_N) begin
            tests_failed++;
            $display("FAIL mult_neg1x2: got %h_%h busy=%0d expected ffffffff_fffffffe busy=%0d", HI, LO, c, MULT_N);
        end
        run_op(4'd2, 32'hFFFFFFFF, 32'h00000002, 1'b1, c);
        tests_run++;
        if (HI !== 32'h00000001 || LO !== 32'hFFFFFFFE || c !== MULT_N) begin
            tests_failed++;
            $display("FAIL multu_max_x2: got %h_%h busy=%0d expected 00000001_fffffffe busy=%0d", HI, LO, c, MULT_N);
        end
    endtask

    task automatic test_div();
        int c;
        run_op(4'd3, 32'hFFFFFFF9, 32'h00000002, 1'b1, c);
        tests_run++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD || c !== DIV_N) begin
            tests_failed++;
            $display("FAIL div_m7_by_2: got %h_%h busy=%0d expected ffffffff_fffffffd busy=%0d", HI, LO, c, DIV_N);
        end
        run_op(4'd4, 32'h00000007, 32'h00000000, 1'b0, c);
        tests_run++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD || c !== DIV_N) begin
            tests_failed++;
            $display("FAIL divu_by_zero: got %h_%h busy=%0d expected ffffffff_fffffffd busy=%0d", HI, LO, c, DIV_N);
        end
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, c);
        tests_run++;
        if (HI !== 32'h00000000 || LO !== 32'h80000000 || c !== DIV_N) begin
            tests_failed++;
            $display("FAIL div_overflow: got %h_%h busy=%0d expected 00000000_80000000 busy=%0d", HI, LO, c, DIV_N);
        end
        run_op(4'd3, 32'h00000007, 32'h00000000, 1'b0, c);
        check_result("div_by_zero", 4'd3, c);
    endtask

    task automatic test_ignore_while_busy();
        int c;
        MDUOp = 4'd1; A = 32'hFFFFFFFF; B = 32'h00000002; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        // Busy cycle 2: mtlo must be ignored.
        MDUOp = 4'd6; A = 32'h12345678; Start = 1'b1;
        tick();
        Start = 1'b0; MDUOp = 4'd0;
        c = 2;
        while (Busy && c < 100) begin tick(); c++; end
        model_apply(4'd1, 32'hFFFFFFFF, 32'h00000002);
        check_result("mtlo_during_busy", 4'd1, c);
        MDUOp = 4'd6; A = 32'h12345678; Start = 1'b1;
        tick();
        Start = 1'b0; MDUOp = 4'd0;
        m_lo = 32'h12345678;
        tests_run++;
        if (LO !== 32'h12345678 || Busy !== 1'b0 || HI !== m_hi) begin
            tests_failed++;
            $display("FAIL mtlo_idle: got lo=%h hi=%h busy=%b expected lo=12345678 hi=%h busy=0", LO, HI, Busy, m_hi);
        end
        // A second start during a divide must not restart or extend it.
        MDUOp = 4'd4; A = 32'd100; B = 32'd7; Start = 1'b1;
        tick();
        MDUOp = 4'd1; A = 32'd3; B = 32'd3;
        c = 0;
        while (Busy && c < 100) begin tick(); c++; end
        Start = 1'b0; MDUOp = 4'd0;
        model_apply(4'd4, 32'd100, 32'd7);
        check_result("start_held_during_div", 4'd4, c);
    endtask

    task automatic test_none_ops();
        logic [3:0] ops [3] = '{4'd0, 4'd7, 4'd15};
        foreach (ops[i]) begin
            MDUOp = ops[i]; A = $urandom; B = $urandom; Start = 1'b1;
            tick();
            Start = 1'b0;
            tests_run++;
            if (Busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
                tests_failed++;
                $display("FAIL none_op_%0d: got busy=%b %h_%h expected busy=0 %h_%h", ops[i], Busy, HI, LO, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_reset_midop();
        MDUOp = 4'd3; A = 32'd100; B = 32'd7; Start = 1'b1;
        tick();
        Start = 1'b0; MDUOp = 4'd0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        tests_run++;
        if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_midop: got busy=%b %h_%h expected busy=0 00000000_00000000", Busy, HI, LO);
        end
        repeat (DIV_N + 3) tick();
        tests_run++;
        if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_midop_late_write: got busy=%b %h_%h expected busy=0 00000000_00000000", Busy, HI, LO);
        end
    endtask

    task automatic test_reset_with_start();
        int c;
        run_op(4'd5, 32'hCAFEF00D, 32'h0, 1'b0, c);
        run_op(4'd6, 32'h0BADBEEF, 32'h0, 1'b0, c);
        tests_run++;
        if (HI !== 32'hCAFEF00D || LO !== 32'h0BADBEEF || c !== 0) begin
            tests_failed++;
            $display("FAIL mthi_mtlo: got %h_%h busy=%0d expected cafef00d_0badbeef busy=0", HI, LO, c);
        end
        MDUOp = 4'd1; A = 32'd9; B = 32'd9; Start = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; Start = 1'b0; MDUOp = 4'd0;
        m_hi = '0; m_lo = '0;
        tests_run++;
        if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_and_start: got busy=%b %h_%h expected busy=0 00000000_00000000", Busy, HI, LO);
        end
        repeat (MULT_N + 2) tick();
        tests_run++;
        if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_and_start_later: got busy=%b %h_%h expected busy=0 00000000_00000000", Busy, HI, LO);
        end
    endtask

    task automatic test_random();
        int          c;
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 6));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            run_op(op, a, b, 1'b1, c);
            check_result($sformatf("random_%0d_op%0d", i, op), op, c);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        run_op(4'd2, 32'hDEADBEEF, 32'h12345678, 1'b0, c);
        check_result("b2b_multu", 4'd2, c);
        run_op(4'd3, 32'h7FFFFFFF, 32'hFFFFFFF0, 1'b0, c);
        check_result("b2b_div", 4'd3, c);
        run_op(4'd1, 32'h80000000, 32'h80000000, 1'b0, c);
        check_result("b2b_mult_minmin", 4'd1, c);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_ignore_while_busy();
        test_none_ops();
        test_reset_midop();
        test_reset_with_start();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
